// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Purpose: sequential instruction fetch front end. A fetch PC addresses a
// combinational instruction ROM; each fetched {pc, instr} pair is queued in a
// 2-entry FIFO that the consumer drains with a valid/ready handshake.
// Redirects flush the queue and reload the PC, aligned down to a word.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   en_i           fetch enable (IDLE/RUN control)
//   redirect_i     branch/jump redirect strobe
//   redirect_pc_i  redirect target byte address
//   rom_addr_o     ROM byte address (the fetch PC)
//   rom_data_i     ROM read data for rom_addr_o, same cycle
//   instr_o        instruction at queue head (zero when empty)
//   pc_o           byte address of instr_o (zero when empty)
//   valid_o        queue head valid
//   ready_i        consumer accepts head this cycle
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 10,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [1:0]              count;
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [ADDR_WIDTH-1:0]   q_pc    [DEPTH];
    logic [DATA_WIDTH-1:0]   q_instr [DEPTH];

    logic                    pop;
    logic                    push;
    logic [ADDR_WIDTH-1:0]   redirect_aligned;

    // Handshake and fetch qualification; a pop frees a slot for the same-cycle push
    assign pop              = (count != 2'd0) & ready_i;
    assign push             = (state == RUN) & en_i & ~redirect_i &
                              ((count != 2'(DEPTH)) | pop);
    assign redirect_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);

    // FSM, fetch PC and FIFO state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
        end else begin
            state <= en_i ? RUN : IDLE;

            if (redirect_i) begin
                // Flush: a same-cycle pop has already completed, the rest is dropped
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                fetch_pc <= redirect_aligned;
            end else begin
                if (push) begin
                    q_pc[wr_ptr]    <= fetch_pc;
                    q_instr[wr_ptr] <= rom_data_i;
                    wr_ptr          <= ~wr_ptr;
                    fetch_pc        <= fetch_pc + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Outputs decoded directly from registered state; head reads zero when empty
    assign rom_addr_o = fetch_pc;
    assign valid_o    = (count != 2'd0);
    assign pc_o       = valid_o ? q_pc[rd_ptr]    : '0;
    assign instr_o    = valid_o ? q_instr[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
// Purpose: self-checking bench for instr_fetch_ctrl. ROM word n holds n.
// A scoreboard queue holds the expected FIFO contents (fetch PCs); entries
// are pushed when a fetch is expected and popped when the consumer accepts.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] pc_o;
    logic          valid_o;
    logic          ready_i;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard / reference state
    logic [AW-1:0] sb_q [$];
    logic [AW-1:0] m_pc;
    logic          m_run;

    instr_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   ('0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // ROM: word n contains n
    assign rom_data_i = DW'(rom_addr_o >> 2);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare all outputs against the scoreboard head and model PC
    task automatic compare_all(input string tag);
        logic          exp_v;
        logic [AW-1:0] exp_pc;
        exp_v  = (sb_q.size() != 0);
        exp_pc = exp_v ? sb_q[0] : '0;
        check({tag, ".valid"}, 32'(valid_o), 32'(exp_v));
        check({tag, ".pc"},    32'(pc_o),    32'(exp_pc));
        check({tag, ".instr"}, instr_o,      exp_v ? 32'(exp_pc >> 2) : 32'd0);
        check({tag, ".addr"},  32'(rom_addr_o), 32'(m_pc));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_pc  = '0;
        m_run = 1'b0;
    endtask

    // One clock: drive inputs at negedge, update scoreboard, check at next negedge
    task automatic step(input logic en, input logic rdy, input logic rd,
                        input logic [AW-1:0] rpc, input string tag);
        logic pop;
        logic push;
        en_i          = en;
        ready_i       = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        pop  = (sb_q.size() != 0) && rdy;
        push = m_run && en && !rd && ((sb_q.size() < 2) || pop);
        if (rd) begin
            sb_q.delete();
            m_pc = {rpc[AW-1:2], 2'b00};
        end else begin
            if (pop)  void'(sb_q.pop_front());
            if (push) begin
                sb_q.push_back(m_pc);
                m_pc = m_pc + AW'(4);
            end
        end
        m_run = en;
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        en_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        #1;
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.addr",  32'(rom_addr_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        compare_all("rst_rel");
    endtask

    initial begin
        rst_i = 1'b0;
        en_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        model_reset();

        // Basic stream, one instruction per cycle
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0, "s32a");
        check("s32.novalid", 32'(valid_o), 32'd0);
        step(1'b1, 1'b1, 1'b0, '0, "s32b");
        check("s32.pc0", 32'(pc_o), 32'h000);
        check("s32.i0",  instr_o,   32'd0);
        step(1'b1, 1'b1, 1'b0, '0, "s32c");
        check("s32.pc4", 32'(pc_o), 32'h004);
        check("s32.i1",  instr_o,   32'd1);
        step(1'b1, 1'b1, 1'b0, '0, "s32d");
        check("s32.pc8", 32'(pc_o), 32'h008);

        // Back-pressure: saturate at two, PC holds at 0x008
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, "s33hold");
        check("s33.addr", 32'(rom_addr_o), 32'h008);
        check("s33.head", 32'(pc_o), 32'h000);
        step(1'b1, 1'b1, 1'b0, '0, "s33r1");
        check("s33.pc4", 32'(pc_o), 32'h004);
        step(1'b1, 1'b1, 1'b0, '0, "s33r2");
        check("s33.pc8", 32'(pc_o), 32'h008);
        step(1'b1, 1'b1, 1'b0, '0, "s33r3");
        check("s33.pcC", 32'(pc_o), 32'h00C);

        // Redirect from full FIFO with a misaligned target
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, "s34fill");
        check("s34.head", 32'(pc_o), 32'h000);
        step(1'b1, 1'b1, 1'b1, AW'(10'h103), "s34rd");
        check("s34.flush", 32'(valid_o), 32'd0);
        check("s34.addr",  32'(rom_addr_o), 32'h100);
        step(1'b1, 1'b1, 1'b0, '0, "s34nx");
        check("s34.pc100", 32'(pc_o), 32'h100);

        // Wrap from the top of the address space
        step(1'b1, 1'b1, 1'b1, AW'(10'h3FC), "s35rd");
        step(1'b1, 1'b1, 1'b0, '0, "s35a");
        check("s35.pc3FC", 32'(pc_o), 32'h3FC);
        step(1'b1, 1'b1, 1'b0, '0, "s35b");
        check("s35.wrap",  32'(pc_o), 32'h000);

        // Fill to two, drop enable, drain with no new fetch
        step(1'b1, 1'b0, 1'b0, '0, "s36fill");
        check("s36.addr0", 32'(rom_addr_o), 32'h008);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, "s36drain");
        check("s36.empty", 32'(valid_o), 32'd0);
        check("s36.addr1", 32'(rom_addr_o), 32'h008);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, '0, "s37run");
        #3;
        rst_i = 1'b1;
        #1;
        check("s37.valid", 32'(valid_o), 32'd0);
        check("s37.addr",  32'(rom_addr_o), 32'd0);
        check("s37.pc",    32'(pc_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        compare_all("s37rel");
        step(1'b1, 1'b1, 1'b0, '0, "s37a");
        step(1'b1, 1'b1, 1'b0, '0, "s37b");
        check("s37.pc0", 32'(pc_o), 32'h000);
        step(1'b1, 1'b1, 1'b0, '0, "s37c");
        check("s37.pc4", 32'(pc_o), 32'h004);

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0,
                 AW'($urandom),
                 "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
